// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: oversample tick, bit tick and phase, with a
// pending-config register that is applied only at safe points so periods never glitch.
module uart_baud_gen_frac #(
  parameter  int DIV_W  = 13,
  parameter  int FRAC_W = 3,
  parameter  int OVS    = 16,
  localparam int OVS_W  = (OVS > 1) ? $clog2(OVS) : 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              EN,
  input  logic [DIV_W-1:0]  BAUD_VAL,
  input  logic [FRAC_W-1:0] BAUD_FRAC,
  input  logic              LOAD,
  input  logic              PHASE_CLR,
  output logic              BAUD_TICK,
  output logic              BIT_TICK,
  output logic [OVS_W-1:0]  PHASE,
  output logic              CFG_PEND
);

  logic [DIV_W:0]    cnt_reg, cnt_next;
  logic [FRAC_W-1:0] acc_reg, acc_next;
  logic [OVS_W-1:0]  phase_reg, phase_next;
  logic              baud_tick_reg, baud_tick_next;
  logic              bit_tick_reg, bit_tick_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [FRAC_W-1:0] frac_reg, frac_next;
  logic [DIV_W-1:0]  pend_div_reg, pend_div_next;
  logic [FRAC_W-1:0] pend_frac_reg, pend_frac_next;
  logic              cfg_pend_reg, cfg_pend_next;

  logic              reload;
  logic              apply;
  logic              phase_wrap;
  logic [FRAC_W:0]   acc_sum;

  always_comb begin
    reload         = (cnt_reg == '0);
    apply          = PHASE_CLR | ~EN | reload;
    phase_wrap     = (phase_reg == OVS_W'(OVS - 1));

    div_next       = div_reg;
    frac_next      = frac_reg;
    pend_div_next  = pend_div_reg;
    pend_frac_next = pend_frac_reg;
    cfg_pend_next  = cfg_pend_reg;

    // A LOAD coinciding with an apply point bypasses the pending registers entirely.
    if (apply) begin
      cfg_pend_next = 1'b0;
      if (LOAD) begin
        div_next  = BAUD_VAL;
        frac_next = BAUD_FRAC;
      end else if (cfg_pend_reg) begin
        div_next  = pend_div_reg;
        frac_next = pend_frac_reg;
      end
    end else if (LOAD) begin
      pend_div_next  = BAUD_VAL;
      pend_frac_next = BAUD_FRAC;
      cfg_pend_next  = 1'b1;
    end

    acc_sum        = {1'b0, acc_reg} + {1'b0, frac_next};

    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    phase_next     = phase_reg;
    baud_tick_next = 1'b0;
    bit_tick_next  = 1'b0;

    if (PHASE_CLR) begin
      cnt_next   = {1'b0, div_next};
      acc_next   = '0;
      phase_next = '0;
    end else if (!EN) begin
      cnt_next   = cnt_reg;
    end else if (reload) begin
      // Carry out of the fractional accumulator stretches this period by one cycle.
      baud_tick_next = 1'b1;
      acc_next       = acc_sum[FRAC_W-1:0];
      cnt_next       = {1'b0, div_next} + (DIV_W + 1)'(acc_sum[FRAC_W]);
      phase_next     = phase_wrap ? '0 : phase_reg + OVS_W'(1);
      bit_tick_next  = phase_wrap;
    end else begin
      cnt_next       = cnt_reg - (DIV_W + 1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_reg       <= '0;
      acc_reg       <= '0;
      phase_reg     <= '0;
      baud_tick_reg <= 1'b0;
      bit_tick_reg  <= 1'b0;
      div_reg       <= BAUD_VAL;
      frac_reg      <= BAUD_FRAC;
      pend_div_reg  <= '0;
      pend_frac_reg <= '0;
      cfg_pend_reg  <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      phase_reg     <= phase_next;
      baud_tick_reg <= baud_tick_next;
      bit_tick_reg  <= bit_tick_next;
      div_reg       <= div_next;
      frac_reg      <= frac_next;
      pend_div_reg  <= pend_div_next;
      pend_frac_reg <= pend_frac_next;
      cfg_pend_reg  <= cfg_pend_next;
    end
  end

  assign BAUD_TICK = baud_tick_reg;
  assign BIT_TICK  = bit_tick_reg;
  assign PHASE     = phase_reg;
  assign CFG_PEND  = cfg_pend_reg;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: directed vector table, fractional/corner sequences,
// then randomized traffic against a tick-counting reference model.
module tb_uart_baud_gen_frac;

  localparam int DIV_W  = 13;
  localparam int FRAC_W = 3;
  localparam int OVS    = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [DIV_W-1:0]  baud_val;
  logic [FRAC_W-1:0] baud_frac;
  logic              load;
  logic              phase_clr;
  logic              baud_tick;
  logic              bit_tick;
  logic [3:0]        phase;
  logic              cfg_pend;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_baud_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
    .CLK(clk), .RESET_N(reset_n), .EN(en), .BAUD_VAL(baud_val), .BAUD_FRAC(baud_frac),
    .LOAD(load), .PHASE_CLR(phase_clr), .BAUD_TICK(baud_tick), .BIT_TICK(bit_tick),
    .PHASE(phase), .CFG_PEND(cfg_pend)
  );

  typedef struct {
    logic        rst_n, en, load, clr;
    logic [12:0] bv;
    logic [2:0]  bf;
    logic        bt, bit_t;
    logic [3:0]  ph;
    logic        pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic l, input logic c,
                              input int bv, input int bf, input logic bt, input logic bit_t,
                              input int ph, input logic pend);
    vec_t v;
    v.rst_n = r; v.en = e; v.load = l; v.clr = c;
    v.bv = 13'(bv); v.bf = 3'(bf);
    v.bt = bt; v.bit_t = bit_t; v.ph = 4'(ph); v.pend = pend;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic c,
                       input int bv, input int bf);
    reset_n = r; en = e; load = l; phase_clr = c;
    baud_val = DIV_W'(bv); baud_frac = FRAC_W'(bf);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: counts enabled edges until the next tick and ticks since the last clear.
  int m_div, m_frac, m_pdiv, m_pfrac, m_wait, m_acc, m_ticks;
  bit m_pend, m_bt, m_bit;

  task automatic model_edge(input bit r, input bit e, input bit l, input bit c,
                            input int bv, input int bf);
    bit ap;
    int carry;
    if (!r) begin
      m_div = bv; m_frac = bf; m_pend = 0; m_wait = 0; m_acc = 0; m_ticks = 0;
      m_bt = 0; m_bit = 0;
      return;
    end
    ap = c || !e || (m_wait == 0);
    if (ap) begin
      if (l) begin m_div = bv; m_frac = bf; end
      else if (m_pend) begin m_div = m_pdiv; m_frac = m_pfrac; end
      m_pend = 0;
    end else if (l) begin
      m_pdiv = bv; m_pfrac = bf; m_pend = 1;
    end
    m_bt = 0; m_bit = 0;
    if (c) begin
      m_wait = m_div; m_acc = 0; m_ticks = 0;
    end else if (e) begin
      if (m_wait == 0) begin
        m_acc   = m_acc + m_frac;
        carry   = (m_acc >= (1 << FRAC_W)) ? 1 : 0;
        m_acc   = m_acc % (1 << FRAC_W);
        m_wait  = m_div + carry;
        m_ticks = m_ticks + 1;
        m_bt    = 1;
        m_bit   = (m_ticks % OVS) == 0;
      end else begin
        m_wait = m_wait - 1;
      end
    end
  endtask

  initial begin
    int ntick, tc[$];
    int pat[8];
    int got, exp;
    bit r, e, l, c;
    int bv, bf;

    pat = '{5, 5, 6, 5, 5, 6, 5, 6};
    drive(0, 0, 0, 0, 4, 0);

    // Directed table: config load, phase clear on a due tick, enable gap, mid-period reset.
    add(0,1,0,0,4,0, 0,0,0,0);
    add(1,1,0,0,4,0, 1,0,1,0);
    add(1,1,0,0,4,0, 0,0,1,0);
    add(1,1,1,0,9,0, 0,0,1,1);
    for (int i = 0; i < 2; i++) add(1,1,0,0,9,0, 0,0,1,1);
    add(1,1,0,0,9,0, 1,0,2,0);
    for (int i = 0; i < 9; i++) add(1,1,0,0,9,0, 0,0,2,0);
    add(1,1,0,0,9,0, 1,0,3,0);
    for (int i = 0; i < 9; i++) add(1,1,0,0,9,0, 0,0,3,0);
    add(1,1,0,1,9,0, 0,0,0,0);
    for (int i = 0; i < 9; i++) add(1,1,0,0,9,0, 0,0,0,0);
    add(1,1,0,0,9,0, 1,0,1,0);
    add(1,0,1,0,4,0, 0,0,1,0);
    for (int i = 0; i < 9; i++) add(1,1,0,0,4,0, 0,0,1,0);
    add(1,1,0,0,4,0, 1,0,2,0);
    for (int i = 0; i < 2; i++) add(1,1,0,0,4,0, 0,0,2,0);
    for (int i = 0; i < 20; i++) add(1,0,0,0,4,0, 0,0,2,0);
    for (int i = 0; i < 2; i++) add(1,1,0,0,4,0, 0,0,2,0);
    add(1,1,0,0,4,0, 1,0,3,0);
    for (int i = 0; i < 2; i++) add(1,1,0,0,7,0, 0,0,3,0);
    add(0,1,0,0,7,0, 0,0,0,0);
    add(1,1,0,0,7,0, 1,0,1,0);
    for (int i = 0; i < 7; i++) add(1,1,0,0,7,0, 0,0,1,0);
    add(1,1,0,0,7,0, 1,0,2,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].load, vecs[i].clr, vecs[i].bv, vecs[i].bf);
      step();
      got = {baud_tick, bit_tick, phase, cfg_pend};
      exp = {vecs[i].bt, vecs[i].bit_t, vecs[i].ph, vecs[i].pend};
      $display("vec %0d rst_n=%0b en=%0b ld=%0b clr=%0b bv=%0d -> tick=%0b bit=%0b ph=%0d pend=%0b",
               i, vecs[i].rst_n, vecs[i].en, vecs[i].load, vecs[i].clr, vecs[i].bv,
               baud_tick, bit_tick, phase, cfg_pend);
      chk($sformatf("vec%0d", i), got, exp);
    end

    // D=4 F=0: tick every 5 cycles from cycle 1, bit tick on every 16th tick.
    drive(0, 1, 0, 0, 4, 0); step();
    drive(1, 1, 0, 0, 4, 0);
    ntick = 0;
    for (int cyc = 1; cyc <= 170; cyc++) begin
      bit et;
      step();
      et = ((cyc - 1) % 5) == 0;
      if (et) ntick++;
      chk("int_period", {baud_tick, bit_tick, phase},
          {et, et && (ntick % 16 == 0), 4'(ntick % 16)});
    end
    $display("seq int_period D=4 ticks=%0d", ntick);

    // D=0 F=0: tick every cycle, bit tick every 16 cycles.
    drive(0, 1, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      chk("d0", {baud_tick, bit_tick, phase}, {1'b1, (cyc % 16) == 0, 4'(cyc % 16)});
    end
    $display("seq d0 done");

    // D=4 F=3: period pattern 5,5,6,5,5,6,5,6 and 43 cycles per 8 ticks.
    drive(0, 1, 0, 0, 4, 3); step();
    drive(1, 1, 0, 0, 4, 3);
    tc.delete();
    for (int cyc = 1; cyc <= 100; cyc++) begin
      step();
      if (baud_tick) tc.push_back(cyc);
    end
    if (tc.size() < 17) begin
      chk("frac_tick_count", tc.size(), 17);
    end else begin
      chk("frac_first", tc[0], 1);
      for (int i = 0; i < 16; i++) chk($sformatf("frac_per%0d", i), tc[i+1] - tc[i], pat[i % 8]);
      chk("frac_span", tc[8] - tc[0], 43);
      chk("frac_span2", tc[16] - tc[8], 43);
    end
    $display("seq frac D=4 F=3 ticks=%0d", tc.size());

    // Randomized traffic against the reference model.
    drive(0, 1, 0, 0, 3, 0);
    model_edge(0, 1, 0, 0, 3, 0);
    step();
    chk("rnd_reset", {baud_tick, bit_tick, phase, cfg_pend}, 0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r  = $urandom_range(0, 299) != 0;
      e  = $urandom_range(0, 9) != 0;
      l  = $urandom_range(0, 14) == 0;
      c  = $urandom_range(0, 39) == 0;
      bv = $urandom_range(0, 6);
      bf = $urandom_range(0, 7);
      drive(r, e, l, c, bv, bf);
      model_edge(r, e, l, c, bv, bf);
      step();
      if (l && r) $display("rnd load cyc=%0d bv=%0d bf=%0d en=%0b clr=%0b", cyc, bv, bf, e, c);
      chk("rnd", {baud_tick, bit_tick, phase, cfg_pend},
          {m_bt, m_bit, 4'(m_ticks % OVS), m_pend});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
